fir_cfg_sequencer: RTL and testbench

- Sequences reconfiguration of the 7-tap FIR filter block through its CPU-style byte write port (w_n, w_en_n, addr, p).
- Accepts a whole 64-bit parameter image via valid/ready: bytes 0-6 are coefficients b0..b6, byte 7 is the input mask.
- Gates the sample stream during reconfiguration and can flush the filter delay line with zero samples afterwards.
- Sits between the system config master / sample source and the filter.

---
 rtl/fir_pkg.sv | 33 +++
 rtl/fir_drop_counter.sv | 30 +++
 rtl/fir_cfg_sequencer.sv | 149 ++++++++++++++
 tb/tb_fir_cfg_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_pkg
// Description : Shared constants, state encoding and helpers for the 7-tap
//               FIR filter configuration path.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

  localparam int FIR_TAPS        = 7;
  localparam int FIR_PARAM_BYTES = 8;
  localparam logic [2:0] FIR_MASK_ADDR = 3'd7;
  localparam int FIR_ADDR_W      = 16;

  // Sequencer states; explicit 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_SETUP = 3'd2,
    ST_LOW   = 3'd3,
    ST_HOLD  = 3'd4,
    ST_FLUSH = 3'd5,
    ST_DONE  = 3'd6
  } fir_seq_state_e;

  // Byte idx of a parameter image (byte 0 = b0 ... byte 7 = input mask)
  function automatic logic [7:0] fir_param_byte(input logic [8*FIR_PARAM_BYTES-1:0] image,
                                                input logic [2:0] idx);
    return image[{idx, 3'b000} +: 8];
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_drop_counter.sv
`default_nettype none
// ============================================================================
// Module      : fir_drop_counter
// Description : Saturating event counter with synchronous clear; clear wins
//               over a simultaneous increment.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_drop_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count events, stick at all-ones, clear has priority
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fir_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fir_cfg_sequencer
// Description : Writes a 64-bit FIR parameter image through the filter's
//               byte write port, gates the sample stream meanwhile and can
//               flush the delay line with zero samples afterwards.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_cfg_sequencer
  import fir_pkg::*;
#(
  parameter int FLUSH_LEN = 7,
  parameter int DROP_W    = 8
) (
  input  logic                         clock,
  input  logic                         rst_n,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [8*FIR_PARAM_BYTES-1:0] cfg_data,
  input  logic [FIR_PARAM_BYTES-1:0]   cfg_be,
  input  logic                         cfg_flush,
  output logic                         cfg_done,
  output logic                         busy,
  output logic                         w_n,
  output logic                         w_en_n,
  output logic [FIR_ADDR_W-1:0]        addr,
  output logic [7:0]                   p,
  input  logic                         x_valid_in,
  input  logic [7:0]                   x_in,
  output logic                         x_valid_out,
  output logic [7:0]                   x_out,
  output logic [DROP_W-1:0]            drop_cnt,
  input  logic                         drop_clr
);

  // Remaining-flush counter holds FLUSH_LEN-1 down to 0
  localparam int   C_FL_W     = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
  localparam logic C_FLUSH_EN = (FLUSH_LEN > 0);

  fir_seq_state_e               r_state;
  fir_seq_state_e               w_next;
  fir_seq_state_e               w_end_state;
  logic [2:0]                   r_k;
  logic [8*FIR_PARAM_BYTES-1:0] r_data;
  logic [FIR_PARAM_BYTES-1:0]   r_be;
  logic                         r_flush;
  logic [C_FL_W-1:0]            r_flush_cnt;
  logic                         w_accept;
  logic                         w_last;
  logic                         w_pass;
  logic                         w_drop_inc;

  assign w_accept    = cfg_valid & cfg_ready;
  assign w_last      = (r_k == FIR_MASK_ADDR);
  assign w_end_state = (r_flush && C_FLUSH_EN) ? ST_FLUSH : ST_DONE;
  // Samples pass only when idle and no request is being taken this cycle
  assign w_pass      = (r_state == ST_IDLE) && !w_accept;
  assign w_drop_inc  = x_valid_in && !w_pass;

  // Next-state decision for the byte walk, flush and completion
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = ST_SCAN;
      ST_SCAN: begin
        if (r_be[r_k])   w_next = ST_SETUP;
        else if (w_last) w_next = w_end_state;
        else             w_next = ST_SCAN;
      end
      ST_SETUP: w_next = ST_LOW;
      ST_LOW:   w_next = ST_HOLD;
      ST_HOLD:  w_next = w_last ? w_end_state : ST_SCAN;
      ST_FLUSH: if (r_flush_cnt == '0) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // State, request latch and all registered outputs (derived from next state)
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_k         <= '0;
      r_data      <= '0;
      r_be        <= '0;
      r_flush     <= 1'b0;
      r_flush_cnt <= '0;
      cfg_ready   <= 1'b0;
      cfg_done    <= 1'b0;
      busy        <= 1'b0;
      w_n         <= 1'b1;
      w_en_n      <= 1'b1;
      addr        <= '0;
      p           <= '0;
      x_valid_out <= 1'b0;
      x_out       <= '0;
    end else begin
      r_state   <= w_next;
      cfg_ready <= (w_next == ST_IDLE);
      busy      <= (w_next != ST_IDLE);
      cfg_done  <= (w_next == ST_DONE);

      if (w_accept) begin
        r_data  <= cfg_data;
        r_be    <= cfg_be;
        r_flush <= cfg_flush;
        r_k     <= '0;
      end else if (((r_state == ST_SCAN) && (w_next != ST_SETUP)) || (r_state == ST_HOLD)) begin
        // Wrap after byte 7 is harmless: the walk has ended by then
        r_k <= r_k + 3'd1;
      end

      // Address/data are presented in SETUP and simply held afterwards
      if (w_next == ST_SETUP) begin
        addr <= {{(FIR_ADDR_W-3){1'b0}}, r_k};
        p    <= fir_param_byte(r_data, r_k);
      end
      w_en_n <= !(w_next inside {ST_SETUP, ST_LOW, ST_HOLD});
      // Rising edge of w_n on entry to HOLD is what the filter latches on
      w_n    <= (w_next != ST_LOW);

      if ((w_next == ST_FLUSH) && (r_state != ST_FLUSH)) begin
        r_flush_cnt <= C_FL_W'(FLUSH_LEN - 1);
      end else if (r_state == ST_FLUSH) begin
        r_flush_cnt <= r_flush_cnt - C_FL_W'(1);
      end

      if (w_pass) begin
        x_valid_out <= x_valid_in;
        x_out       <= x_in;
      end else begin
        x_valid_out <= (w_next == ST_FLUSH);
        x_out       <= '0;
      end
    end
  end

  fir_drop_counter #(
    .WIDTH (DROP_W)
  ) u_drop_counter (
    .clock (clock),
    .rst_n (rst_n),
    .clr   (drop_clr),
    .inc   (w_drop_inc),
    .count (drop_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_fir_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_cfg_sequencer
// Description : Directed self-checking bench for fir_cfg_sequencer with a
//               behavioural filter write-port model. A second instance with
//               DROP_W=2, FLUSH_LEN=0 shares all inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_cfg_sequencer;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [63:0] cfg_data = '0;
  logic [7:0]  cfg_be = '0;
  logic        cfg_flush = 1'b0;
  logic        x_valid_in = 1'b0;
  logic [7:0]  x_in = '0;
  logic        drop_clr = 1'b0;

  logic        cfg_ready, cfg_done, busy, w_n, w_en_n, x_valid_out;
  logic [15:0] addr;
  logic [7:0]  p, x_out, drop_cnt;

  logic        d2_cfg_ready, d2_cfg_done, d2_busy, d2_w_n, d2_w_en_n, d2_x_valid_out;
  logic [15:0] d2_addr;
  logic [7:0]  d2_p, d2_x_out;
  logic [1:0]  d2_drop_cnt;

  fir_cfg_sequencer #(.FLUSH_LEN(7), .DROP_W(8)) dut (
    .clock(clock), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_data(cfg_data), .cfg_be(cfg_be), .cfg_flush(cfg_flush), .cfg_done(cfg_done),
    .busy(busy), .w_n(w_n), .w_en_n(w_en_n), .addr(addr), .p(p),
    .x_valid_in(x_valid_in), .x_in(x_in), .x_valid_out(x_valid_out), .x_out(x_out),
    .drop_cnt(drop_cnt), .drop_clr(drop_clr)
  );

  fir_cfg_sequencer #(.FLUSH_LEN(0), .DROP_W(2)) dut2 (
    .clock(clock), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(d2_cfg_ready),
    .cfg_data(cfg_data), .cfg_be(cfg_be), .cfg_flush(cfg_flush), .cfg_done(d2_cfg_done),
    .busy(d2_busy), .w_n(d2_w_n), .w_en_n(d2_w_en_n), .addr(d2_addr), .p(d2_p),
    .x_valid_in(x_valid_in), .x_in(x_in), .x_valid_out(d2_x_valid_out), .x_out(d2_x_out),
    .drop_cnt(d2_drop_cnt), .drop_clr(drop_clr)
  );

  always #5 clock = ~clock;

  // Filter write-port model: latch p into addr on rising w_n while enabled
  logic [7:0]  img [0:7];
  logic [15:0] s_addr [$];
  logic [7:0]  s_p [$];
  int          n_strobe = 0;
  always @(posedge w_n) begin
    if (rst_n && !w_en_n) begin
      img[addr[2:0]] = p;
      s_addr.push_back(addr);
      s_p.push_back(p);
      n_strobe++;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Per-sequence observations; cycle index 1 = acceptance cycle
  int done_idx, d2_done_idx, n_wen_low, flush_first, flush_cnt, flush_nz, drop_at_clr;

  task automatic run_seq(input logic [63:0] data, input logic [7:0] be, input logic fl,
                         input bit hold, input int clr_at);
    int idx;
    check_eq("ready_before_accept", {63'd0, cfg_ready}, 64'd1);
    cfg_data = data; cfg_be = be; cfg_flush = fl; cfg_valid = 1'b1;
    done_idx = 0; d2_done_idx = 0; n_wen_low = 0;
    flush_first = 0; flush_cnt = 0; flush_nz = 0; drop_at_clr = -1;
    tick();
    if (!hold) cfg_valid = 1'b0;
    idx = 2;
    for (int i = 0; i < 200 && done_idx == 0; i++) begin
      if (!w_en_n) n_wen_low++;
      if (x_valid_out) begin
        flush_cnt++;
        if (flush_first == 0) flush_first = idx;
        if (x_out != 8'h00) flush_nz++;
      end
      if (idx == clr_at + 1) drop_at_clr = int'(drop_cnt);
      if (d2_cfg_done && d2_done_idx == 0) d2_done_idx = idx;
      if (cfg_done) done_idx = idx;
      drop_clr = (idx == clr_at);
      if (done_idx == 0) begin
        tick();
        idx++;
      end
    end
    drop_clr = 1'b0;
  endtask

  function automatic logic [63:0] pack_addr(input int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n && i < s_addr.size(); i++) v[i*8 +: 8] = s_addr[i][7:0];
    return v;
  endfunction

  function automatic logic [63:0] pack_p(input int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n && i < s_p.size(); i++) v[i*8 +: 8] = s_p[i];
    return v;
  endfunction

  function automatic logic [63:0] pack_img();
    logic [63:0] v = '0;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = img[i];
    return v;
  endfunction

  initial begin
    int guard;
    // ---------------- reset values ----------------
    repeat (3) tick();
    check_eq("rst_cfg_ready", {63'd0, cfg_ready}, 64'd0);
    check_eq("rst_w_n", {63'd0, w_n}, 64'd1);
    check_eq("rst_w_en_n", {63'd0, w_en_n}, 64'd1);
    check_eq("rst_addr", {48'd0, addr}, 64'd0);
    check_eq("rst_p", {56'd0, p}, 64'd0);
    check_eq("rst_x_valid_out", {63'd0, x_valid_out}, 64'd0);
    check_eq("rst_busy_done", {62'd0, busy, cfg_done}, 64'd0);
    check_eq("rst_drop_cnt", {56'd0, drop_cnt}, 64'd0);
    rst_n = 1'b1;
    tick();
    check_eq("ready_after_release", {63'd0, cfg_ready}, 64'd1);

    // ---------------- idle passthrough ----------------
    x_valid_in = 1'b1; x_in = 8'h5A;
    tick();
    check_eq("pass_valid", {63'd0, x_valid_out}, 64'd1);
    check_eq("pass_data", {56'd0, x_out}, 64'h5A);
    check_eq("pass_no_drop", {56'd0, drop_cnt}, 64'd0);
    x_valid_in = 1'b0;
    tick();
    check_eq("pass_valid_low", {63'd0, x_valid_out}, 64'd0);

    // ---------------- full load, samples arriving every cycle ----------------
    // accept(1) + 8 bytes x 4 (2..33) + DONE(34)
    x_valid_in = 1'b1; x_in = 8'hAA;
    run_seq(64'hFF07_0605_0403_0201, 8'hFF, 1'b0, 1'b0, 0);
    check_eq("full_done_idx", 64'(done_idx), 64'd34);
    check_eq("full_busy_at_done", {62'd0, busy, cfg_ready}, 64'b10);
    check_eq("full_strobes", 64'(n_strobe), 64'd8);
    check_eq("full_addr_seq", pack_addr(8), 64'h0706_0504_0302_0100);
    check_eq("full_p_seq", pack_p(8), 64'hFF07_0605_0403_0201);
    check_eq("full_image", pack_img(), 64'hFF07_0605_0403_0201);
    check_eq("full_wen_low_cycles", 64'(n_wen_low), 64'd24);
    check_eq("full_no_flush", 64'(flush_cnt), 64'd0);
    check_eq("full_d2_done_idx", 64'(d2_done_idx), 64'd34);
    tick();
    // 34 busy cycles each carried a dropped sample (acceptance and DONE included)
    check_eq("full_drop_cnt", {56'd0, drop_cnt}, 64'd34);
    check_eq("d2_drop_saturated", {62'd0, d2_drop_cnt}, 64'd3);
    check_eq("after_done_idle", {61'd0, x_valid_out, busy, cfg_ready}, 64'b001);
    x_in = 8'h33;
    tick();
    check_eq("first_after_done", {55'd0, x_valid_out, x_out}, {55'd0, 1'b1, 8'h33});
    x_valid_in = 1'b0; drop_clr = 1'b1;
    tick();
    drop_clr = 1'b0;
    check_eq("drop_clr", {56'd0, drop_cnt}, 64'd0);

    // ---------------- sparse load with request held (backpressure) ----------------
    // accept(1) + byte0(4) + bytes1..6 scan(6) + byte7(4) -> DONE at 16
    s_addr.delete(); s_p.delete(); n_strobe = 0;
    run_seq(64'hFF07_0605_0403_0201, 8'b1000_0001, 1'b0, 1'b1, 0);
    check_eq("sparse_done_idx", 64'(done_idx), 64'd16);
    check_eq("sparse_strobes", 64'(n_strobe), 64'd2);
    check_eq("sparse_addr_seq", pack_addr(2), 64'h0700);
    check_eq("sparse_p_seq", pack_p(2), 64'hFF01);
    check_eq("sparse_wen_low_cycles", 64'(n_wen_low), 64'd6);
    check_eq("held_ready_at_done", {63'd0, cfg_ready}, 64'd0);
    tick();
    check_eq("held_idle_cycle", {62'd0, busy, cfg_ready}, 64'b01);
    tick();
    check_eq("held_reaccepted", {62'd0, busy, cfg_ready}, 64'b10);
    cfg_valid = 1'b0;
    guard = 0;
    while (!cfg_done && guard < 100) begin tick(); guard++; end
    check_eq("reaccept_done_seen", {63'd0, cfg_done}, 64'd1);
    check_eq("reaccept_strobes", 64'(n_strobe), 64'd4);
    tick();

    // ---------------- flushed load with drop_clr mid-way ----------------
    // bytes end at 33, flush 34..40, DONE 41; FLUSH_LEN=0 copy finishes at 34
    s_addr.delete(); s_p.delete(); n_strobe = 0;
    x_valid_in = 1'b1; x_in = 8'hAA;
    run_seq(64'h8011_2233_4455_6677, 8'hFF, 1'b1, 1'b0, 10);
    check_eq("flush_done_idx", 64'(done_idx), 64'd41);
    check_eq("flush_cycles", 64'(flush_cnt), 64'd7);
    check_eq("flush_first_idx", 64'(flush_first), 64'd34);
    check_eq("flush_data_zero", 64'(flush_nz), 64'd0);
    check_eq("flush_image", pack_img(), 64'h8011_2233_4455_6677);
    check_eq("d2_no_flush_done_idx", 64'(d2_done_idx), 64'd34);
    check_eq("clr_beats_inc", 64'(drop_at_clr), 64'd0);
    tick();
    // cleared at the edge ending cycle 10; cycles 11..41 counted
    check_eq("flush_drop_cnt", {56'd0, drop_cnt}, 64'd31);
    check_eq("d2_drop_resaturated", {62'd0, d2_drop_cnt}, 64'd3);
    x_valid_in = 1'b0;

    // ---------------- async reset during LOW of byte 3 ----------------
    s_addr.delete(); s_p.delete(); n_strobe = 0;
    cfg_data = 64'hFF07_0605_0403_0201; cfg_be = 8'hFF; cfg_flush = 1'b0; cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    guard = 0;
    while (!(w_n == 1'b0 && addr == 16'd3) && guard < 100) begin tick(); guard++; end
    check_eq("reached_low_byte3", {63'd0, (w_n == 1'b0 && addr == 16'd3)}, 64'd1);
    check_eq("strobes_before_reset", 64'(n_strobe), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_strobes_idle", {62'd0, w_n, w_en_n}, 64'b11);
    check_eq("arst_busy_ready", {62'd0, busy, cfg_ready}, 64'b00);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check_eq("arst_ready_after_release", {63'd0, cfg_ready}, 64'd1);
    repeat (40) tick();
    check_eq("arst_no_more_strobes", 64'(n_strobe), 64'd3);
    check_eq("arst_still_idle", {62'd0, busy, cfg_done}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Absolute time limit
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
